mem_rmw_ctrl: RTL and testbench

Front-end controller for a 1-read/1-write SRAM macro whose write port has no byte-enable, such as the rf2 wm1 family. It takes single-port requests (read, or write with per-byte mask) and sequences them onto the macro's R0/W0 ports. Partial-mask writes are implemented as a pipelined read-modify-write. A one-entry bypass hides read-during-write hazards. It sits between a core-side requester and the memory wrapper instance.

---
 rtl/mem_rmw_ctrl_if.sv | 27 ++
 rtl/mem_rmw_ctrl.sv | 107 ++++++++++
 tb/tb_mem_rmw_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_rmw_ctrl_if.sv
// Requester-side bus of mem_rmw_ctrl: single-port request channel plus
// read-response pulse. The controller takes the slave modport.
interface mem_rmw_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int WIDTH  = 64,
  parameter int MASK_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [WIDTH-1:0]  req_wdata;
  logic [MASK_W-1:0] req_mask;
  logic              rsp_valid;
  logic [WIDTH-1:0]  rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_mask,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_mask,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/mem_rmw_ctrl.sv
// Front-end for a 1R/1W SRAM macro without byte enables: reads pass through,
// partial-mask writes become a two-stage read-modify-write with a one-entry bypass.
module mem_rmw_ctrl #(
  parameter int DEPTH     = 48,
  parameter int WIDTH     = 64,
  parameter int MASK_GRAN = 8,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_rmw_ctrl_if.slave     bus,
  output logic [ADDR_W-1:0] R0_addr,
  output logic              R0_en,
  input  logic [WIDTH-1:0]  R0_data,
  output logic [ADDR_W-1:0] W0_addr,
  output logic              W0_en,
  output logic [WIDTH-1:0]  W0_data
);

  localparam int unsigned     MASK_W  = WIDTH / MASK_GRAN;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  logic              ready_q;
  logic              a_fire;
  logic              a_in_range;
  logic              a_mask_full;
  logic              a_mask_zero;

  logic              b_valid;
  logic              b_write;
  logic              b_err;
  logic [ADDR_W-1:0] b_addr;
  logic [WIDTH-1:0]  b_wdata;
  logic [MASK_W-1:0] b_mask;

  logic              fwd_hit;
  logic [WIDTH-1:0]  fwd_data;
  logic [ADDR_W-1:0] r0_addr_q;
  logic [ADDR_W-1:0] w0_addr_q;

  logic [WIDTH-1:0]  base;
  logic [WIDTH-1:0]  merged;
  logic              rsp_fire;

  // Stage A: decode the incoming request and issue the macro read
  always_comb begin
    a_fire      = bus.req_valid && ready_q;
    a_in_range  = {1'b0, bus.req_addr} < DEPTH_A;
    a_mask_full = &bus.req_mask;
    a_mask_zero = ~|bus.req_mask;
    R0_en       = a_fire && a_in_range &&
                  (!bus.req_write || (!a_mask_full && !a_mask_zero));
    R0_addr     = R0_en ? bus.req_addr : r0_addr_q;
  end

  // Stage B: merge against either the macro output or the forwarded word
  always_comb begin
    base   = fwd_hit ? fwd_data : R0_data;
    merged = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      merged[i*MASK_GRAN +: MASK_GRAN] = b_mask[i] ? b_wdata[i*MASK_GRAN +: MASK_GRAN]
                                                   : base[i*MASK_GRAN +: MASK_GRAN];
    end
    W0_en    = b_valid && b_write;
    W0_addr  = W0_en ? b_addr : w0_addr_q;
    W0_data  = merged;
    rsp_fire = b_valid && !b_write;
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_fire;
  assign bus.rsp_err   = rsp_fire && b_err;
  assign bus.rsp_data  = (rsp_fire && !b_err) ? base : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      b_valid   <= 1'b0;
      b_write   <= 1'b0;
      b_err     <= 1'b0;
      b_addr    <= '0;
      b_wdata   <= '0;
      b_mask    <= '0;
      fwd_hit   <= 1'b0;
      fwd_data  <= '0;
      r0_addr_q <= '0;
      w0_addr_q <= '0;
    end else begin
      ready_q   <= 1'b1;
      // Zero-mask and out-of-range writes never enter stage B
      b_valid   <= a_fire && (bus.req_write ? (a_in_range && !a_mask_zero) : 1'b1);
      b_write   <= bus.req_write;
      b_err     <= !a_in_range;
      b_addr    <= bus.req_addr;
      b_wdata   <= bus.req_wdata;
      b_mask    <= bus.req_mask;
      r0_addr_q <= R0_addr;
      w0_addr_q <= W0_addr;
      // Macro read-during-write output is undefined; serve the next stage from W0_data
      fwd_hit   <= R0_en && W0_en && (R0_addr == W0_addr);
      if (R0_en && W0_en && (R0_addr == W0_addr)) begin
        fwd_data <= W0_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Self-checking bench for mem_rmw_ctrl: table-driven request stream with
// per-cycle port checks, plus a response scoreboard fed from a reference memory.
module tb_mem_rmw_ctrl;

  localparam int DEPTH  = 48;
  localparam int WIDTH  = 64;
  localparam int GRAN   = 8;
  localparam int ADDR_W = 6;
  localparam int MASK_W = WIDTH / GRAN;

  typedef struct {
    logic              valid;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
    logic [MASK_W-1:0] mask;
    logic              exp_r0;
    logic              exp_w0;
    logic [WIDTH-1:0]  exp_wd;
  } vec_t;

  typedef struct {
    int               cyc;
    logic             err;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] R0_addr;
  logic              R0_en;
  logic [WIDTH-1:0]  R0_data;
  logic [ADDR_W-1:0] W0_addr;
  logic              W0_en;
  logic [WIDTH-1:0]  W0_data;

  mem_rmw_ctrl_if #(.ADDR_W(ADDR_W), .WIDTH(WIDTH), .MASK_W(MASK_W)) bus ();

  mem_rmw_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_GRAN(GRAN), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .R0_addr (R0_addr),
    .R0_en   (R0_en),
    .R0_data (R0_data),
    .W0_addr (W0_addr),
    .W0_en   (W0_en),
    .W0_data (W0_data)
  );

  logic [WIDTH-1:0] mem     [0:63];
  logic [WIDTH-1:0] ref_mem [0:63];
  exp_t             sb [$];
  vec_t             vec [15];
  int               cyc;
  int               tests;
  int               failed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Macro model: 1-cycle read latency, read-during-write to the same word returns junk
  always @(posedge clk) begin
    if (R0_en)
      R0_data <= (W0_en && W0_addr == R0_addr) ? 64'hBAD0_BAD0_BAD0_BAD0 : mem[R0_addr];
    if (W0_en)
      mem[W0_addr] <= W0_data;
  end

  function automatic logic [WIDTH-1:0] init_word(input int i);
    case (i)
      7:       return 64'hFFFF_FFFF_FFFF_FFFF;
      9:       return 64'h0;
      10:      return 64'h0102_0304_0506_0708;
      default: return 64'hA5A5_0000_0000_0000 | 64'(i);
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_w,
                                             input logic [WIDTH-1:0] wd,
                                             input logic [MASK_W-1:0] m);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < MASK_W; i++)
      r[i*GRAN +: GRAN] = m[i] ? wd[i*GRAN +: GRAN] : old_w[i*GRAN +: GRAN];
    return r;
  endfunction

  function automatic vec_t mk(input logic v, input logic w, input int a,
                              input logic [WIDTH-1:0] d, input logic [MASK_W-1:0] m,
                              input logic r0, input logic w0, input logic [WIDTH-1:0] wd);
    vec_t t;
    t.valid = v; t.wr = w; t.addr = ADDR_W'(a); t.wdata = d; t.mask = m;
    t.exp_r0 = r0; t.exp_w0 = w0; t.exp_wd = wd;
    return t;
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one request and update the reference model / scoreboard
  task automatic drive(input vec_t v);
    exp_t e;
    bus.req_valid = v.valid;
    bus.req_write = v.wr;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_mask  = v.mask;
    if (v.valid) begin
      if (v.wr) begin
        if (int'(v.addr) < DEPTH && v.mask != '0)
          ref_mem[v.addr] = merge(ref_mem[v.addr], v.wdata, v.mask);
      end else begin
        e.cyc  = cyc + 1;
        e.err  = (int'(v.addr) >= DEPTH);
        e.data = e.err ? '0 : ref_mem[v.addr];
        sb.push_back(e);
      end
    end
  endtask

  // Response monitor: every pulse must match the oldest expectation, in its cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          tests++; failed++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 data=%h, expected no response", bus.rsp_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_cycle", 64'(cyc), 64'(e.cyc));
          check("rsp_err",   64'(bus.rsp_err), 64'(e.err));
          check("rsp_data",  bus.rsp_data, e.data);
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        tests++; failed++;
        $display("FAIL missing_rsp: got rsp_valid=0, expected response due in cycle %0d", sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic             prev_w0;
    logic [WIDTH-1:0] prev_wd;
    vec_t             idle;

    tests = 0; failed = 0; cyc = 0;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end
    idle = mk(0, 0, 0, '0, '0, 0, 0, '0);

    //            v  wr addr data                    mask   r0 w0 exp W0_data
    vec[0]  = mk(1, 0,  5, '0,                     8'h00, 1, 0, '0);
    vec[1]  = mk(1, 1,  3, 64'h1122334455667788,   8'hFF, 0, 1, 64'h1122334455667788);
    vec[2]  = mk(1, 0,  3, '0,                     8'h00, 1, 0, '0);
    vec[3]  = mk(1, 1,  7, 64'h0,                  8'h0F, 1, 1, 64'hFFFFFFFF00000000);
    vec[4]  = mk(1, 1,  9, 64'hAA,                 8'h01, 1, 1, 64'h00000000000000AA);
    vec[5]  = mk(1, 1,  9, 64'hBB00,               8'h02, 1, 1, 64'h000000000000BBAA);
    vec[6]  = mk(1, 0,  9, '0,                     8'h00, 1, 0, '0);
    vec[7]  = mk(1, 1, 10, 64'hFFEEDDCC11223344,   8'hF0, 1, 1, 64'hFFEEDDCC05060708);
    vec[8]  = mk(1, 0, 10, '0,                     8'h00, 1, 0, '0);
    vec[9]  = mk(1, 0, 48, '0,                     8'h00, 0, 0, '0);
    vec[10] = mk(1, 1, 50, 64'h1234,               8'hFF, 0, 0, '0);
    vec[11] = mk(1, 1,  4, 64'h5678,               8'h00, 0, 0, '0);
    vec[12] = idle;
    vec[13] = mk(1, 0,  7, '0,                     8'h00, 1, 0, '0);
    vec[14] = idle;

    rst_n = 1'b0;
    drive(idle);
    #1;
    check("reset_req_ready", 64'(bus.req_ready), 64'd0);
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_rsp_err",   64'(bus.rsp_err),   64'd0);
    check("reset_rsp_data",  bus.rsp_data,       64'd0);
    check("reset_R0_en",     64'(R0_en),         64'd0);
    check("reset_W0_en",     64'(W0_en),         64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 64'(bus.req_ready), 64'd1);

    prev_w0 = 1'b0;
    prev_wd = '0;
    for (int k = 0; k < 15; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      drive(vec[k]);
      @(negedge clk);
      check($sformatf("R0_en[%0d]", k), 64'(R0_en), 64'(vec[k].exp_r0));
      if (vec[k].exp_r0)
        check($sformatf("R0_addr[%0d]", k), 64'(R0_addr), 64'(vec[k].addr));
      check($sformatf("W0_en[%0d]", k), 64'(W0_en), 64'(prev_w0));
      if (prev_w0)
        check($sformatf("W0_data[%0d]", k - 1), W0_data, prev_wd);
      prev_w0 = vec[k].exp_w0;
      prev_wd = vec[k].exp_wd;
    end

    // Reset in the middle of a read-modify-write: the merge must never reach the macro
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 6'd20;
    bus.req_wdata = 64'hEE; bus.req_mask = 8'h01;
    @(posedge clk); #1;
    drive(idle);
    check("rmw_W0_en_before_reset", 64'(W0_en), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rmw_W0_en_in_reset",   64'(W0_en),         64'd0);
    check("rmw_ready_in_reset",   64'(bus.req_ready), 64'd0);
    check("rmw_rsp_valid_reset",  64'(bus.rsp_valid), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    drive(mk(1, 0, 20, '0, 8'h00, 1, 0, '0));
    @(posedge clk); #1;
    drive(idle);

    for (int n = 0; n < 10 && sb.size() != 0; n++) @(posedge clk);
    @(posedge clk); #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
